// File: rtl/rom_load_sequencer.sv
// ROM download sequencer between hps_io and the time_pilot core: registers and
// range-checks each ioctl byte, decodes its ROM region and gates the core reset.
module rom_load_sequencer #(
  parameter logic [15:0] CPU_END  = 16'h6000,
  parameter logic [15:0] SND_END  = 16'h7000,
  parameter logic [15:0] CHR_END  = 16'h9000,
  parameter logic [15:0] SPR_END  = 16'hD000,
  parameter logic [15:0] IMG_END  = 16'hD240,
  parameter int unsigned RST_HOLD = 16
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        user_reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic [15:0] dn_addr,
  output logic [7:0]  dn_data,
  output logic        dn_wr,
  output logic [4:0]  region_sel,
  output logic        core_reset,
  output logic        rom_ready,
  output logic        load_error,
  output logic [16:0] byte_count
);

  localparam int CW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [CW-1:0] HOLD_RELOAD = CW'(RST_HOLD - 1);

  typedef enum logic [2:0] {
    S_WAIT,
    S_LOAD,
    S_CHECK,
    S_HOLD,
    S_RUN
  } state_t;

  state_t          state;
  logic            dl_q;
  logic [CW-1:0]   hold_cnt;
  logic            dl_rise;
  logic            in_range;
  logic [4:0]      region;
  logic            size_bad;

  // A boundary address belongs to the region above it, hence strict less-than.
  always_comb begin
    dl_rise  = ioctl_download & ~dl_q;
    in_range = (ioctl_addr[24:16] == 9'd0) && (ioctl_addr[15:0] < IMG_END);
    size_bad = (byte_count != {1'b0, IMG_END});
    if (ioctl_addr[15:0] < CPU_END)      region = 5'b00001;
    else if (ioctl_addr[15:0] < SND_END) region = 5'b00010;
    else if (ioctl_addr[15:0] < CHR_END) region = 5'b00100;
    else if (ioctl_addr[15:0] < SPR_END) region = 5'b01000;
    else                                 region = 5'b10000;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state      <= S_WAIT;
      dl_q       <= 1'b0;
      hold_cnt   <= '0;
      dn_addr    <= '0;
      dn_data    <= '0;
      dn_wr      <= 1'b0;
      region_sel <= '0;
      core_reset <= 1'b1;
      rom_ready  <= 1'b0;
      load_error <= 1'b0;
      byte_count <= '0;
    end else begin
      dl_q       <= ioctl_download;
      dn_wr      <= 1'b0;
      region_sel <= '0;
      // A new download overrides every other event, in any state.
      if (dl_rise) begin
        state      <= S_LOAD;
        byte_count <= '0;
        load_error <= 1'b0;
        rom_ready  <= 1'b0;
        core_reset <= 1'b1;
      end else begin
        case (state)
          S_WAIT: core_reset <= 1'b1;
          S_LOAD: begin
            core_reset <= 1'b1;
            if (ioctl_wr) begin
              if (in_range) begin
                dn_addr    <= ioctl_addr[15:0];
                dn_data    <= ioctl_dout;
                dn_wr      <= 1'b1;
                region_sel <= region;
                if (byte_count != 17'h1FFFF) byte_count <= byte_count + 17'd1;
              end else begin
                load_error <= 1'b1;
              end
            end
            if (!ioctl_download) state <= S_CHECK;
          end
          S_CHECK: begin
            if (size_bad) load_error <= 1'b1;
            if (size_bad || load_error) begin
              state <= S_WAIT;
            end else begin
              rom_ready <= 1'b1;
              hold_cnt  <= HOLD_RELOAD;
              state     <= S_HOLD;
            end
          end
          S_HOLD: begin
            core_reset <= 1'b1;
            if (user_reset) begin
              hold_cnt <= HOLD_RELOAD;
            end else if (hold_cnt == '0) begin
              state      <= S_RUN;
              core_reset <= 1'b0;
            end else begin
              hold_cnt <= hold_cnt - CW'(1);
            end
          end
          S_RUN: begin
            if (user_reset) begin
              state      <= S_HOLD;
              hold_cnt   <= HOLD_RELOAD;
              core_reset <= 1'b1;
            end else begin
              core_reset <= 1'b0;
            end
          end
          default: begin
            state      <= S_WAIT;
            core_reset <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rom_load_sequencer.sv
// Directed + randomized bench for rom_load_sequencer; a byte-level reference
// model predicts every registered output cycle by cycle.
module tb_rom_load_sequencer;

  localparam logic [15:0] IMG_END = 16'hD240;
  localparam logic [15:0] BOUNDS [5] = '{16'h6000, 16'h7000, 16'h9000, 16'hD000, 16'hD240};
  localparam logic [15:0] RD_ADDR [8] = '{16'h5FFF, 16'h6000, 16'h6FFF, 16'h7000,
                                          16'h8FFF, 16'h9000, 16'hCFFF, 16'hD000};
  localparam logic [4:0]  RD_EXP  [8] = '{5'b00001, 5'b00010, 5'b00010, 5'b00100,
                                          5'b00100, 5'b01000, 5'b01000, 5'b10000};

  logic        clk_sys = 1'b0;
  logic        reset = 1'b0;
  logic        user_reset = 1'b0;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic [15:0] dn_addr;
  logic [7:0]  dn_data;
  logic        dn_wr;
  logic [4:0]  region_sel;
  logic        core_reset;
  logic        rom_ready;
  logic        load_error;
  logic [16:0] byte_count;

  int          compared = 0;
  int          mismatched = 0;
  logic        loading = 1'b0;
  logic [15:0] exp_addr = '0;
  logic [7:0]  exp_data = '0;
  logic [16:0] exp_count = '0;
  int          obs_pulses = 0;

  rom_load_sequencer dut (
    .clk_sys(clk_sys),
    .reset(reset),
    .user_reset(user_reset),
    .ioctl_download(ioctl_download),
    .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout),
    .dn_addr(dn_addr),
    .dn_data(dn_data),
    .dn_wr(dn_wr),
    .region_sel(region_sel),
    .core_reset(core_reset),
    .rom_ready(rom_ready),
    .load_error(load_error),
    .byte_count(byte_count)
  );

  always #5 clk_sys = ~clk_sys;

  function automatic logic [4:0] region_of(input logic [15:0] a);
    for (int i = 0; i < 5; i++)
      if (a < BOUNDS[i]) return 5'(1 << i);
    return 5'b00000;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // One clock of stimulus; outputs are then compared with the byte-level model.
  task automatic apply_stimulus(input logic dl, input logic wr, input logic [24:0] a, input logic [7:0] d);
    logic acc;
    ioctl_download = dl;
    ioctl_wr       = wr;
    ioctl_addr     = a;
    ioctl_dout     = d;
    @(posedge clk_sys);
    #1;
    acc = loading && wr && (a[24:16] == 9'd0) && (a[15:0] < IMG_END);
    if (acc) begin
      exp_addr = a[15:0];
      exp_data = d;
      if (exp_count != 17'h1FFFF) exp_count = exp_count + 17'd1;
    end
    if (dn_wr === 1'b1) obs_pulses++;
    check_output("dn_wr", 32'(dn_wr), 32'(acc));
    check_output("dn_addr", 32'(dn_addr), 32'(exp_addr));
    check_output("dn_data", 32'(dn_data), 32'(exp_data));
    check_output("region_sel", 32'(region_sel), acc ? 32'(region_of(a[15:0])) : 32'd0);
    check_output("byte_count", 32'(byte_count), 32'(exp_count));
    ioctl_wr = 1'b0;
  endtask

  task automatic idle();
    apply_stimulus(ioctl_download, 1'b0, 25'd0, 8'd0);
  endtask

  task automatic load_byte(input logic [24:0] a, input logic [7:0] d);
    apply_stimulus(1'b1, 1'b1, a, d);
  endtask

  task automatic start_download();
    exp_count  = '0;
    obs_pulses = 0;
    loading    = 1'b0;
    apply_stimulus(1'b1, 1'b0, 25'd0, 8'd0);
    loading = 1'b1;
    check_output("start_load_error", 32'(load_error), 32'd0);
    check_output("start_rom_ready", 32'(rom_ready), 32'd0);
    check_output("start_core_reset", 32'(core_reset), 32'd1);
  endtask

  task automatic end_download(input logic wr, input logic [24:0] a, input logic [7:0] d);
    apply_stimulus(1'b0, wr, a, d);
    loading = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_dn_addr"}, 32'(dn_addr), 32'd0);
    check_output({tag, "_dn_data"}, 32'(dn_data), 32'd0);
    check_output({tag, "_dn_wr"}, 32'(dn_wr), 32'd0);
    check_output({tag, "_region_sel"}, 32'(region_sel), 32'd0);
    check_output({tag, "_core_reset"}, 32'(core_reset), 32'd1);
    check_output({tag, "_rom_ready"}, 32'(rom_ready), 32'd0);
    check_output({tag, "_load_error"}, 32'(load_error), 32'd0);
    check_output({tag, "_byte_count"}, 32'(byte_count), 32'd0);
  endtask

  initial begin
    int          fall_k;
    logic [24:0] ra;

    // Power-on reset.
    #1 reset = 1'b1;
    repeat (2) @(posedge clk_sys);
    #1;
    check_reset_values("por");
    reset = 1'b0;

    // A stray strobe outside a download must not reach the core.
    apply_stimulus(1'b0, 1'b1, 25'h0000100, 8'($urandom));
    check_output("wait_core_reset", 32'(core_reset), 32'd1);

    // Region boundaries.
    start_download();
    for (int i = 0; i < 8; i++) begin
      load_byte({9'd0, RD_ADDR[i]}, 8'($urandom));
      check_output("region_table", 32'(region_sel), 32'(RD_EXP[i]));
      idle();
    end
    end_download(1'b0, 25'd0, 8'd0);
    idle();
    check_output("region_short_error", 32'(load_error), 32'd1);
    check_output("region_core_reset", 32'(core_reset), 32'd1);

    // Out-of-range bytes mixed into random traffic.
    start_download();
    load_byte(25'h0010000, 8'($urandom));
    check_output("oor_high_error", 32'(load_error), 32'd1);
    load_byte(25'h000D240, 8'($urandom));
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) ra = 25'($urandom);
      else ra = 25'($urandom_range(0, 32'h0000D23F));
      load_byte(ra, 8'($urandom));
    end
    end_download(1'b0, 25'd0, 8'd0);
    repeat (30) idle();
    check_output("oor_load_error", 32'(load_error), 32'd1);
    check_output("oor_rom_ready", 32'(rom_ready), 32'd0);
    check_output("oor_core_reset", 32'(core_reset), 32'd1);

    // Short image: CPU ROM only.
    start_download();
    for (int a = 0; a < 32'h6000; a++) load_byte(25'(a), 8'($urandom));
    end_download(1'b0, 25'd0, 8'd0);
    idle();
    check_output("short_count", 32'(byte_count), 32'h06000);
    check_output("short_load_error", 32'(load_error), 32'd1);
    check_output("short_rom_ready", 32'(rom_ready), 32'd0);
    repeat (40) idle();
    check_output("short_core_reset", 32'(core_reset), 32'd1);

    // Full image; the last byte arrives in the same cycle download falls.
    start_download();
    for (int a = 0; a < 32'hD23F; a++) load_byte(25'(a), 8'(a));
    end_download(1'b1, 25'h000D23F, 8'h3F);
    check_output("full_check_rom_ready", 32'(rom_ready), 32'd0);
    check_output("full_pulses", 32'(obs_pulses), 32'h0000D240);
    fall_k = 0;
    for (int k = 1; k <= 40 && fall_k == 0; k++) begin
      idle();
      if (k == 1) begin
        check_output("full_rom_ready", 32'(rom_ready), 32'd1);
        check_output("full_load_error", 32'(load_error), 32'd0);
        check_output("full_count", 32'(byte_count), 32'h0D240);
      end
      if (core_reset === 1'b0) fall_k = k;
    end
    check_output("full_release_delay", 32'(fall_k + 1), 32'd18);

    // User reset in RUN, held for three cycles.
    user_reset = 1'b1;
    idle();
    check_output("ureset_core_reset", 32'(core_reset), 32'd1);
    idle();
    idle();
    user_reset = 1'b0;
    fall_k = 0;
    for (int j = 1; j <= 40 && fall_k == 0; j++) begin
      idle();
      if (core_reset === 1'b0) fall_k = j;
    end
    check_output("ureset_release_delay", 32'(fall_k), 32'd16);
    check_output("ureset_rom_ready", 32'(rom_ready), 32'd1);

    // Download edge during HOLD.
    user_reset = 1'b1;
    idle();
    user_reset = 1'b0;
    repeat (3) idle();
    check_output("hold_core_reset", 32'(core_reset), 32'd1);
    start_download();
    check_output("hold_dl_byte_count", 32'(byte_count), 32'd0);

    // Asynchronous reset after 100 bytes, with download still asserted.
    for (int i = 0; i < 100; i++) load_byte(25'($urandom_range(0, 32'h0000D23F)), 8'($urandom));
    #2 reset = 1'b1;
    #1;
    check_reset_values("async");
    loading   = 1'b0;
    exp_count = '0;
    exp_addr  = '0;
    exp_data  = '0;
    #1 reset = 1'b0;
    start_download();
    for (int i = 0; i < 5; i++) load_byte(25'($urandom_range(0, 32'h0000D23F)), 8'($urandom));
    check_output("restart_count", 32'(byte_count), 32'd5);
    end_download(1'b0, 25'd0, 8'd0);
    idle();
    check_output("restart_load_error", 32'(load_error), 32'd1);
    check_output("restart_core_reset", 32'(core_reset), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/rom_load_sequencer.md
# rom_load_sequencer

Sequences ROM image download from the HPS ioctl stream into the `time_pilot` core, in the `clk_sys` domain between `hps_io` and `time_pilot`. Validates and registers each byte, decodes its target ROM region, counts accepted bytes and checks the image length. Holds the core in reset during and after download, and releases it only after a complete, error-free load plus a fixed reset-stretch period. Also stretches user/OSD reset requests.

## Interface
Parameters:
- `CPU_END`, default 16'h6000: first address past main CPU ROM; region 0 is 0 .. CPU_END-1.
- `SND_END`, default 16'h7000: first address past sound CPU ROM (region 1).
- `CHR_END`, default 16'h9000: first address past character ROM (region 2).
- `SPR_END`, default 16'hD000: first address past sprite ROM (region 3).
- `IMG_END`, default 16'hD240: first address past PROMs (region 4); also the required image length.
- `RST_HOLD`, default 16: number of `clk_sys` cycles `core_reset` is held after leaving CHECK or after `user_reset`.

Ports (clock and reset first):
- `clk_sys`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `user_reset`  in  1  level request (OSD reset | button); stretched.
- `ioctl_download`  in  1  download in progress.
- `ioctl_wr`  in  1  one-cycle byte strobe.
- `ioctl_addr`  in  25  byte address.
- `ioctl_dout`  in  8  byte data.
- `dn_addr`  out  16  registered address to core.
- `dn_data`  out  8  registered data to core.
- `dn_wr`  out  1  registered write strobe to core.
- `region_sel`  out  5  one-hot region of current `dn_wr` (bit0 CPU .. bit4 PROM).
- `core_reset`  out  1  reset to core.
- `rom_ready`  out  1  last download complete and valid.
- `load_error`  out  1  sticky; set on out-of-range byte or short image.
- `byte_count`  out  17  accepted bytes in current/last download, saturating at 17'h1FFFF.

## Operation
- States: WAIT, LOAD, CHECK, HOLD, RUN. Reset state is WAIT.
- Reset values: `dn_*`=0, `region_sel`=0, `core_reset`=1, `rom_ready`=0, `load_error`=0, `byte_count`=0.
- WAIT: `core_reset`=1. On `ioctl_download` rising edge → LOAD.
- LOAD entry (download rising edge, from any state):
  - clear `byte_count`, `load_error`, `rom_ready`.
  - `core_reset`=1.
- LOAD, on `ioctl_wr`:
  - If `ioctl_addr[24:16]`==0 and `ioctl_addr[15:0]` < IMG_END: accept. Register addr/data, pulse `dn_wr`, set `region_sel` by comparison against the *_END boundaries (boundary address belongs to the next region), and increment `byte_count`.
  - Otherwise: drop the byte, set `load_error`, and do not increment `byte_count`.
- LOAD → CHECK when `ioctl_download`=0. A strobe in the same cycle that download falls is still processed.
- CHECK lasts 1 cycle:
  - If `byte_count` != IMG_END, set `load_error`.
  - If `load_error` (new or existing) → WAIT.
  - Else set `rom_ready` → HOLD with hold counter = RST_HOLD-1.
- HOLD: `core_reset`=1. Counter decrements each cycle; at 0 → RUN.
  - `user_reset`=1 reloads the counter.
  - Download rising edge → LOAD.
- RUN: `core_reset`=0.
  - `user_reset`=1 → HOLD with counter reloaded.
  - Download rising edge → LOAD.
- Priority when events coincide: download edge > `user_reset` > counter expiry.
- `user_reset` in WAIT or LOAD has no effect; the core is already held.
- Download edge detection uses a registered copy of `ioctl_download`. That copy resets to 0, so a download already high when `reset` deasserts is detected as an edge.
- `dn_addr`/`dn_data` hold their last values between strobes. `region_sel` clears to 0 on any cycle without `dn_wr`.

## Timing
- Accepted byte: `dn_wr`/`dn_addr`/`dn_data`/`region_sel` are valid exactly 1 cycle after `ioctl_wr`, for 1 cycle.
- `byte_count` updates on the same edge as `dn_wr`.
- Download falls at cycle t:
  - CHECK at t+1.
  - HOLD from t+2.
  - `core_reset` falls at t+2+RST_HOLD.
  - `rom_ready` is high from t+2.
- `user_reset` in RUN: `core_reset`=1 on the next edge and stays high for RST_HOLD cycles after `user_reset` deasserts.
- Back-to-back `ioctl_wr` on consecutive cycles must each be accepted; no throughput limit.
- Asynchronous `reset` mid-LOAD: all outputs return to reset values immediately, and the state is WAIT.

## Test plan
- Full load: write addresses 0..16'hD23F with data = addr[7:0], then drop download. Expect 16'hD240 `dn_wr` pulses, `byte_count`=17'h0D240, `load_error`=0, `rom_ready`=1, and `core_reset` falling 18 cycles after the download falls (RST_HOLD=16).
- Region decode: single writes at 16'h5FFF, 6000, 6FFF, 7000, 8FFF, 9000, CFFF, D000. Expect `region_sel` 00001, 00010, 00010, 00100, 00100, 01000, 01000, 10000.
- Out-of-range: write at 25'h010000 and at 16'hD240 during a full load. Expect no `dn_wr` for those bytes, `load_error`=1, state WAIT after CHECK, and `core_reset` staying 1.
- Short image: load only 0..16'h5FFF. Expect `byte_count`=17'h06000, `load_error`=1, `rom_ready`=0, and `core_reset`=1 indefinitely. A subsequent full load recovers to RUN.
- User reset: in RUN, pulse `user_reset` for 3 cycles. Expect `core_reset` high from the next edge until 16 cycles after release. A download edge during HOLD goes to LOAD and clears `rom_ready`.
- Async reset mid-load after 100 bytes: all outputs return to reset values and `byte_count`=0. Download still high on release restarts LOAD.
